// File: rtl/fpu_align_add.sv
// fpu_align_add -- operand alignment and significand add/subtract stage of the
// binary32 FPU adder. It feeds fpu_normalization through a two-stage valid/ready
// pipeline:
//   S1 unpacks both operands, swaps them by magnitude, right-aligns the smaller
//      significand with sticky collapse and resolves NaN/Inf specials.
//   S2 performs the effective add or subtract and fixes the result sign.
// Build option: define FPU_ALIGN_SUBNORM_EN to align subnormal inputs
// (hidden = 0, effective exponent 1). Without it the stage flushes any
// exp == 0 operand to a signed zero before the swap.

module fpu_align_add (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   input  logic        in_op_sub,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_sign,
   output logic        out_is_add_path,
   output logic        out_carry,
   output logic [26:0] out_mant,
   output logic [7:0]  out_exp,
   output logic        out_special,
   output logic [31:0] out_special_word
);

   localparam logic [31:0] QNAN_WORD = 32'h7FC0_0000;
   localparam logic [7:0]  EXP_MAX   = 8'hFF;

   // ---------------------------------------------------------------
   // Pipeline registers
   // ---------------------------------------------------------------
   logic        s1_valid_q;
   logic        s1_sub_q;
   logic        s1_sign_q;
   logic [26:0] s1_l_q;
   logic [26:0] s1_s_q;
   logic [7:0]  s1_exp_q;
   logic        s1_special_q;
   logic [31:0] s1_word_q;

   logic        s2_valid_q;
   logic        s2_sign_q;
   logic        s2_add_q;
   logic        s2_carry_q;
   logic [26:0] s2_mant_q;
   logic [7:0]  s2_exp_q;
   logic        s2_special_q;
   logic [31:0] s2_word_q;

   // ---------------------------------------------------------------
   // Handshake: a stage moves when it is empty or its consumer moves
   // ---------------------------------------------------------------
   logic s1_adv;
   logic s2_adv;

   assign s2_adv   = ~s2_valid_q | out_ready;
   assign s1_adv   = ~s1_valid_q | s2_adv;
   assign in_ready = ~rst & s1_adv;

   // ---------------------------------------------------------------
   // S1 combinational: unpack, swap, align, specials
   // ---------------------------------------------------------------
   logic        a_sign, b_sign_eff;
   logic [7:0]  a_exp, b_exp;
   logic [22:0] a_frac_raw, b_frac_raw;
   logic [22:0] a_frac, b_frac;
   logic        a_hid, b_hid;
   logic [7:0]  a_eexp, b_eexp;
   logic [30:0] a_mag, b_mag;
   logic [26:0] a_sig, b_sig;
   logic        a_is_l;

   logic [26:0] l_sig, s_sig;
   logic [7:0]  l_eexp, s_eexp;
   logic        l_sign;
   logic        l_zero;
   logic [7:0]  shift_amt;
   logic [26:0] s_shifted;
   logic [26:0] lost_mask;
   logic        sticky;
   logic [26:0] s_aligned;

   logic        a_nan, b_nan, a_inf, b_inf;

   logic        s1_sub_d;
   logic        s1_sign_d;
   logic [26:0] s1_l_d;
   logic [26:0] s1_s_d;
   logic [7:0]  s1_exp_d;
   logic        s1_special_d;
   logic [31:0] s1_word_d;

   // Unpack both operands into significand / effective exponent form
   always_comb begin
      a_sign     = in_a[31];
      b_sign_eff = in_b[31] ^ in_op_sub;
      a_exp      = in_a[30:23];
      b_exp      = in_b[30:23];
      a_frac_raw = in_a[22:0];
      b_frac_raw = in_b[22:0];
      a_hid      = (a_exp != 8'd0);
      b_hid      = (b_exp != 8'd0);
`ifdef FPU_ALIGN_SUBNORM_EN
      // Subnormals keep their fraction and align as if their exponent were 1
      a_frac     = a_frac_raw;
      b_frac     = b_frac_raw;
      a_eexp     = a_hid ? a_exp : 8'd1;
      b_eexp     = b_hid ? b_exp : 8'd1;
`else
      // Denormals-are-zero: an exp == 0 operand becomes a signed zero
      a_frac     = a_hid ? a_frac_raw : 23'd0;
      b_frac     = b_hid ? b_frac_raw : 23'd0;
      a_eexp     = a_exp;
      b_eexp     = b_exp;
`endif
      a_mag      = {a_exp, a_frac};
      b_mag      = {b_exp, b_frac};
      a_sig      = {a_hid, a_frac, 3'b000};
      b_sig      = {b_hid, b_frac, 3'b000};
      // On an exact magnitude tie, a stays the larger operand
      a_is_l     = (a_mag >= b_mag);
   end

   // Swap by magnitude and right-align the smaller significand with sticky
   always_comb begin
      if (a_is_l) begin
         l_sig  = a_sig;
         s_sig  = b_sig;
         l_eexp = a_eexp;
         s_eexp = b_eexp;
         l_sign = a_sign;
         l_zero = (a_mag == 31'd0);
      end else begin
         l_sig  = b_sig;
         s_sig  = a_sig;
         l_eexp = b_eexp;
         s_eexp = a_eexp;
         l_sign = b_sign_eff;
         l_zero = (b_mag == 31'd0);
      end

      shift_amt = l_eexp - s_eexp;
      lost_mask = ~(27'h7FF_FFFF << shift_amt[4:0]);
      s_shifted = s_sig >> shift_amt[4:0];
      sticky    = |(s_sig & lost_mask);

      if (shift_amt >= 8'd27) begin
         // Everything falls below the sticky position
         s_aligned = (s_sig != 27'd0) ? 27'd1 : 27'd0;
      end else begin
         s_aligned = s_shifted | {26'd0, sticky};
      end

      s1_sub_d  = a_sign ^ b_sign_eff;
      s1_sign_d = l_sign;
      s1_l_d    = l_sig;
      s1_s_d    = s_aligned;
      // Both-zero reports exponent 0 even when subnormals align at exponent 1
      s1_exp_d  = l_zero ? 8'd0 : l_eexp;
   end

   // Resolve NaN / Inf results from the raw encodings
   always_comb begin
      a_nan = (a_exp == EXP_MAX) && (a_frac_raw != 23'd0);
      b_nan = (b_exp == EXP_MAX) && (b_frac_raw != 23'd0);
      a_inf = (a_exp == EXP_MAX) && (a_frac_raw == 23'd0);
      b_inf = (b_exp == EXP_MAX) && (b_frac_raw == 23'd0);

      if (a_nan || b_nan) begin
         s1_special_d = 1'b1;
         s1_word_d    = QNAN_WORD;
      end else if (a_inf && b_inf) begin
         s1_special_d = 1'b1;
         // Opposite effective signs is Inf - Inf
         if (a_sign != b_sign_eff) begin
            s1_word_d = QNAN_WORD;
         end else begin
            s1_word_d = {a_sign, EXP_MAX, 23'd0};
         end
      end else if (a_inf) begin
         s1_special_d = 1'b1;
         s1_word_d    = {a_sign, EXP_MAX, 23'd0};
      end else if (b_inf) begin
         s1_special_d = 1'b1;
         s1_word_d    = {b_sign_eff, EXP_MAX, 23'd0};
      end else begin
         s1_special_d = 1'b0;
         s1_word_d    = 32'd0;
      end
   end

   // S1 register: capture a new operand pair whenever the stage may advance
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q   <= 1'b0;
         s1_sub_q     <= 1'b0;
         s1_sign_q    <= 1'b0;
         s1_l_q       <= 27'd0;
         s1_s_q       <= 27'd0;
         s1_exp_q     <= 8'd0;
         s1_special_q <= 1'b0;
         s1_word_q    <= 32'd0;
      end else if (s1_adv) begin
         s1_valid_q <= in_valid;
         if (in_valid) begin
            s1_sub_q     <= s1_sub_d;
            s1_sign_q    <= s1_sign_d;
            s1_l_q       <= s1_l_d;
            s1_s_q       <= s1_s_d;
            s1_exp_q     <= s1_exp_d;
            s1_special_q <= s1_special_d;
            s1_word_q    <= s1_word_d;
         end
      end
   end

   // ---------------------------------------------------------------
   // S2 combinational: effective add / subtract
   // ---------------------------------------------------------------
   logic [27:0] sum_w;
   logic [26:0] diff_w;
   logic        s2_sign_d;
   logic        s2_carry_d;
   logic [26:0] s2_mant_d;

   // Add or subtract the aligned significands; L >= S so no borrow exists
   always_comb begin
      sum_w  = {1'b0, s1_l_q} + {1'b0, s1_s_q};
      diff_w = s1_l_q - s1_s_q;
      if (s1_sub_q) begin
         s2_carry_d = 1'b0;
         s2_mant_d  = diff_w;
         // Exact cancellation yields +0
         s2_sign_d  = (diff_w == 27'd0) ? 1'b0 : s1_sign_q;
      end else begin
         s2_carry_d = sum_w[27];
         s2_mant_d  = sum_w[26:0];
         s2_sign_d  = s1_sign_q;
      end
   end

   // S2 register: outputs hold while downstream stalls
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_valid_q   <= 1'b0;
         s2_sign_q    <= 1'b0;
         s2_add_q     <= 1'b0;
         s2_carry_q   <= 1'b0;
         s2_mant_q    <= 27'd0;
         s2_exp_q     <= 8'd0;
         s2_special_q <= 1'b0;
         s2_word_q    <= 32'd0;
      end else if (s2_adv) begin
         s2_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            s2_sign_q    <= s2_sign_d;
            s2_add_q     <= ~s1_sub_q;
            s2_carry_q   <= s2_carry_d;
            s2_mant_q    <= s2_mant_d;
            s2_exp_q     <= s1_exp_q;
            s2_special_q <= s1_special_q;
            s2_word_q    <= s1_word_q;
         end
      end
   end

   assign out_valid        = s2_valid_q;
   assign out_sign         = s2_sign_q;
   assign out_is_add_path  = s2_add_q;
   assign out_carry        = s2_carry_q;
   assign out_mant         = s2_mant_q;
   assign out_exp          = s2_exp_q;
   assign out_special      = s2_special_q;
   assign out_special_word = s2_word_q;

endmodule
